// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and types for the oversampling SPI frame slave
package spi_pkg;

  localparam int ERR_W = 8;

  typedef enum logic {
    SAMPLE_FALL = 1'b0,
    SAMPLE_RISE = 1'b1
  } sample_edge_e;

  function automatic int frame_w(input int word_w, input int n_words);
    return word_w * n_words;
  endfunction

endpackage

// File: rtl/spi_frame_slave_sync_edge.sv
// rtl/spi_frame_slave_sync_edge.sv - multi-flop synchroniser with registered edge detect
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_sr <= '0;
      q_d     <= 1'b0;
    end else begin
      sync_sr <= {sync_sr[STAGES-2:0], d};
      q_d     <= sync_sr[STAGES-1];
    end
  end

  assign q    = sync_sr[STAGES-1];
  assign rise = sync_sr[STAGES-1] & ~q_d;
  assign fall = ~sync_sr[STAGES-1] & q_d;

endmodule

// File: rtl/spi_frame_slave.sv
// rtl/spi_frame_slave.sv - system-clocked SPI frame slave with double-buffered vsync publish
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int N_WORDS     = 1,
  parameter int SAMPLE_RISE = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  localparam int FRAME_W    = frame_w(WORD_W, N_WORDS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdo,
  output logic               sdi,
  input  logic               update,
  input  logic [FRAME_W-1:0] tx_data,
  output logic [FRAME_W-1:0] q,
  output logic               q_new,
  output logic               stale,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int CNT_W  = $clog2(FRAME_W);
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam sample_edge_e EDGE_SEL = (SAMPLE_RISE != 0) ? spi_pkg::SAMPLE_RISE : spi_pkg::SAMPLE_FALL;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic sck_rise, sck_fall, sdo_s, upd_rise;
  logic sck_level_unused, sdo_rise_unused, sdo_fall_unused, upd_level_unused, upd_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .reset(reset), .d(sck),
    .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sdo_sync (
    .clk(clk), .reset(reset), .d(sdo),
    .q(sdo_s), .rise(sdo_rise_unused), .fall(sdo_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_upd_sync (
    .clk(clk), .reset(reset), .d(update),
    .q(upd_level_unused), .rise(upd_rise), .fall(upd_fall_unused)
  );

  logic                sample_edge, shift_edge;
  logic [CNT_W-1:0]    bit_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [FRAME_W-2:0]  rx_sr;
  logic [FRAME_W-1:0]  rx_next;
  logic [FRAME_W-1:0]  rx_buf;
  logic [FRAME_W-1:0]  tx_sr;
  logic                fresh;

  assign sample_edge = (EDGE_SEL == spi_pkg::SAMPLE_RISE) ? sck_rise : sck_fall;
  assign shift_edge  = (EDGE_SEL == spi_pkg::SAMPLE_RISE) ? sck_fall : sck_rise;
  assign rx_next     = {rx_sr, sdo_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= '0;
      q_new    <= 1'b0;
      stale    <= 1'b0;
      err_cnt  <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      rx_sr    <= '0;
      rx_buf   <= '0;
      tx_sr    <= '0;
      fresh    <= 1'b0;
    end else begin
      q_new <= 1'b0;
      // Publish sees the pre-edge rx_buf/fresh; a frame completing this cycle re-sets fresh below.
      if (upd_rise) begin
        q <= rx_buf;
        if (fresh) begin
          q_new <= 1'b1;
          stale <= 1'b0;
          fresh <= 1'b0;
        end else begin
          stale <= 1'b1;
        end
      end

      if (sample_edge) begin
        rx_sr    <= rx_next[FRAME_W-2:0];
        idle_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          rx_buf  <= rx_next;
          fresh   <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end else if (shift_edge && bit_cnt != '0) begin
        tx_sr    <= {tx_sr[FRAME_W-2:0], 1'b0};
        idle_cnt <= '0;
      end else if (bit_cnt != '0) begin
        if (idle_cnt == IDLE_LAST) begin
          bit_cnt  <= '0;
          rx_sr    <= '0;
          idle_cnt <= '0;
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end else begin
        idle_cnt <= '0;
      end

      if (bit_cnt == '0 && !sample_edge) tx_sr <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sdi <= 1'b0;
    else       sdi <= tx_sr[FRAME_W-1];
  end

endmodule

// File: tb/tb_spi_frame_slave.sv
// tb/tb_spi_frame_slave.sv - table-driven and scoreboard bench for spi_frame_slave
`timescale 1ns/1ps
module tb_spi_frame_slave;

  logic        clk = 1'b0;
  logic        reset, reset_b;
  logic        sck_a, sdo_a, upd_a, sdi_a, q_new_a, stale_a;
  logic [31:0] tx_a, q_a;
  logic [7:0]  err_a;
  logic        sck_b, sdo_b, upd_b, sdi_b, q_new_b, stale_b;
  logic [63:0] tx_b, q_b;
  logic [7:0]  err_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];

  always #12.5 clk = ~clk;

  spi_frame_slave dut_a (
    .clk(clk), .reset(reset), .sck(sck_a), .sdo(sdo_a), .sdi(sdi_a), .update(upd_a),
    .tx_data(tx_a), .q(q_a), .q_new(q_new_a), .stale(stale_a), .err_cnt(err_a)
  );

  spi_frame_slave #(.N_WORDS(2), .SAMPLE_RISE(1)) dut_b (
    .clk(clk), .reset(reset_b), .sck(sck_b), .sdo(sdo_b), .sdi(sdi_b), .update(upd_b),
    .tx_data(tx_b), .q(q_b), .q_new(q_new_b), .stale(stale_b), .err_cnt(err_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every q_new pulse must match the next expected published frame.
  always @(negedge clk) begin
    if (q_new_a) begin
      checks++;
      if (exp_q_a.size() == 0) begin
        errors++;
        $display("FAIL q_new_a_unexpected actual=%h expected=no_pulse", q_a);
      end else begin
        logic [31:0] e;
        e = exp_q_a.pop_front();
        if (q_a !== e) begin
          errors++;
          $display("FAIL q_new_a_data actual=%h expected=%h", q_a, e);
        end
      end
    end
    if (q_new_b) begin
      checks++;
      if (exp_q_b.size() == 0) begin
        errors++;
        $display("FAIL q_new_b_unexpected actual=%h expected=no_pulse", q_b);
      end else begin
        logic [63:0] e;
        e = exp_q_b.pop_front();
        if (q_b !== e) begin
          errors++;
          $display("FAIL q_new_b_data actual=%h expected=%h", q_b, e);
        end
      end
    end
  end

  // PIC model: data is left-aligned in 64 bits, bits [63-first ..] sent MSB first.
  task automatic xfer(input bit use_b, input logic [63:0] data, input int first, input int count,
                      input bit collide, output logic [63:0] got);
    logic bv;
    got = '0;
    for (int i = first; i < first + count; i++) begin
      bv = data[63-i];
      if (use_b) begin sdo_b = bv; sck_b = 1'b0; end
      else       begin sdo_a = bv; sck_a = 1'b1; end
      #500;
      got = {got[62:0], (use_b ? sdi_b : sdi_a)};
      if (use_b) sck_b = 1'b1;
      else begin
        sck_a = 1'b0;
        if (collide && i == first + count - 1) upd_a = 1'b1;
      end
      #500;
    end
  endtask

  task automatic publish_a(input bit expect_new, input logic [31:0] exp_q, input string name);
    if (expect_new) exp_q_a.push_back(exp_q);
    upd_a = 1'b1;
    repeat (8) @(negedge clk);
    check({name, "_q"}, q_a, exp_q);
    check({name, "_stale"}, stale_a, !expect_new);
    upd_a = 1'b0;
    repeat (8) @(negedge clk);
    check({name, "_q_new_missing"}, exp_q_a.size(), 0);
    exp_q_a.delete();
  endtask

  task automatic frame_a(input logic [31:0] rx, input logic [31:0] tx, input string name);
    logic [63:0] got;
    tx_a = tx;
    repeat (4) @(negedge clk);
    xfer(1'b0, {rx, 32'h0}, 0, 32, 1'b0, got);
    check({name, "_tx_bits"}, got[31:0], tx);
  endtask

  typedef struct {
    logic [31:0] rx;
    logic [31:0] tx;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [63:0] got, got2;

    vecs[0] = '{32'hA5C3_0F81, 32'h1234_5678};
    vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{32'h8000_0001, 32'hC0DE_5A5A};

    reset = 1'b1; reset_b = 1'b1;
    sck_a = 1'b0; sdo_a = 1'b0; upd_a = 1'b0; tx_a = 32'hFFFF_FFFF;
    sck_b = 1'b0; sdo_b = 1'b0; upd_b = 1'b0; tx_b = 64'h0123_4567_89AB_CDEF;
    repeat (5) @(negedge clk);
    check("rst_q", q_a, 0);
    check("rst_q_new", q_new_a, 0);
    check("rst_stale", stale_a, 0);
    check("rst_err", err_a, 0);
    check("rst_sdi", sdi_a, 0);
    reset = 1'b0; reset_b = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      frame_a(vecs[i].rx, vecs[i].tx, $sformatf("vec%0d", i));
      publish_a(1'b1, vecs[i].rx, $sformatf("vec%0d_pub", i));
    end

    // Publish with no traffic in between: stale, no pulse, q held.
    publish_a(1'b0, vecs[3].rx, "stale_pub");
    frame_a(32'h0BAD_F00D, 32'h7E57_0001, "after_stale");
    publish_a(1'b1, 32'h0BAD_F00D, "after_stale_pub");

    // Timeout resync after a 13-bit partial frame.
    tx_a = 32'h5555_AAAA;
    repeat (4) @(negedge clk);
    xfer(1'b0, 64'hFFF8_0000_0000_0000, 0, 13, 1'b0, got);
    repeat (1100) @(negedge clk);
    check("timeout_err", err_a, 1);
    check("timeout_q_held", q_a, 32'h0BAD_F00D);
    frame_a(32'hCAFE_F00D, 32'h5555_AAAA, "post_timeout");
    publish_a(1'b1, 32'hCAFE_F00D, "post_timeout_pub");
    check("timeout_err_after", err_a, 1);

    // Last sample edge and update rise in the same clk.
    tx_a = 32'h0F0F_F0F0;
    repeat (4) @(negedge clk);
    xfer(1'b0, {32'h1357_2468, 32'h0}, 0, 32, 1'b1, got);
    check("collide_tx_bits", got[31:0], 32'h0F0F_F0F0);
    repeat (8) @(negedge clk);
    check("collide_q_prev", q_a, 32'hCAFE_F00D);
    check("collide_stale", stale_a, 1);
    upd_a = 1'b0;
    repeat (8) @(negedge clk);
    publish_a(1'b1, 32'h1357_2468, "collide_next_pub");

    // Reset after 10 bits discards the partial frame and clears err_cnt.
    xfer(1'b0, 64'hFFC0_0000_0000_0000, 0, 10, 1'b0, got);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_q", q_a, 0);
    check("midrst_q_new", q_new_a, 0);
    check("midrst_stale", stale_a, 0);
    check("midrst_err", err_a, 0);
    check("midrst_sdi", sdi_a, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    frame_a(32'h2468_ACE1, 32'h9ABC_DEF0, "post_reset");
    publish_a(1'b1, 32'h2468_ACE1, "post_reset_pub");

    // Two-word frame sampled on rising sck.
    repeat (4) @(negedge clk);
    xfer(1'b1, 64'hDEAD_BEEF_0000_0001, 0, 63, 1'b0, got);
    repeat (4) @(negedge clk);
    check("b_rx_buf_bit63", dut_b.rx_buf, 64'h0);
    xfer(1'b1, 64'hDEAD_BEEF_0000_0001, 63, 1, 1'b0, got2);
    repeat (4) @(negedge clk);
    check("b_rx_buf_bit64", dut_b.rx_buf, 64'hDEAD_BEEF_0000_0001);
    check("b_tx_bits", {got[62:0], got2[0]}, 64'h0123_4567_89AB_CDEF);
    exp_q_b.push_back(64'hDEAD_BEEF_0000_0001);
    upd_b = 1'b1;
    repeat (8) @(negedge clk);
    check("b_q", q_b, 64'hDEAD_BEEF_0000_0001);
    check("b_stale", stale_b, 0);
    check("b_err", err_b, 0);
    upd_b = 1'b0;
    repeat (8) @(negedge clk);
    check("b_q_new_missing", exp_q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
- Parametrised successor to the PIC-link SPI slave.
- Runs entirely in the system clock domain, oversampling sck/sdo/update, instead of clocking flops from sck with an async reset.
- Supports multi-word frames, a selectable sample edge, and an idle-timeout resync that counts framing errors.
- Received frames are double-buffered and published to the game logic on the vsync rising edge.

Parameters:
- WORD_W, 32, bits per word.
- N_WORDS, 1, words per frame; FRAME_W = WORD_W*N_WORDS.
- SAMPLE_RISE, 0, 0 = sample sdo on falling sck and shift sdi on rising; 1 = the reverse.
- SYNC_STAGES, 2, synchroniser depth for sck, sdo, update (>=2).
- TIMEOUT, 1024, clk cycles without an sck edge mid-frame before resync.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from PIC (asynchronous).
- sdo  in  1  serial data from PIC (asynchronous).
- sdi  out  1  serial data to PIC.
- update  in  1  vsync level (asynchronous); its rising edge publishes a frame.
- tx_data  in  FRAME_W  frame to send; word 0 in the MSBs, sent MSB first.
- q  out  FRAME_W  last published received frame.
- q_new  out  1  one-cycle pulse when q was loaded with a frame not previously published.
- stale  out  1  high if the last publish found no new frame.
- err_cnt  out  8  saturating count of timeout resyncs.

Behaviour:
- Reset values: q=0, q_new=0, stale=0, err_cnt=0, sdi=0, bit_cnt=0, rx_sr=0, rx_buf=0, tx_sr=0, fresh=0, idle_cnt=0. Synchroniser flops reset to 0.
- Synchronisation: sck, sdo and update each pass through SYNC_STAGES flops. One further flop on sck_s and update_s gives the edge detects. A sample or shift edge is a one-cycle pulse, 2 to SYNC_STAGES+1 cycles after the pin transition.
- Idle load: while bit_cnt==0 and there is no sample edge this cycle, tx_sr <= tx_data every cycle. sdi = tx_sr[FRAME_W-1] (registered) at all times.
- Sample edge:
  - rx_sr <= {rx_sr[FRAME_W-2:0], sdo_s}; bit_cnt++; idle_cnt <= 0.
  - If bit_cnt == FRAME_W-1: rx_buf <= {rx_sr[FRAME_W-2:0], sdo_s}; fresh <= 1; bit_cnt <= 0.
- Shift edge:
  - If bit_cnt != 0: tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0}; idle_cnt <= 0.
  - If bit_cnt == 0 (leading idle edge), the edge is ignored.
- Timeout:
  - While bit_cnt != 0 and there is no edge, idle_cnt++.
  - At idle_cnt == TIMEOUT-1: bit_cnt <= 0, rx_sr discarded (rx_buf and fresh unchanged), err_cnt++ saturating at 255, idle_cnt <= 0. tx_sr reloads via the idle-load rule from the next cycle.
  - idle_cnt is held at 0 while bit_cnt == 0.
- Publish (update_s rising edge):
  - q <= rx_buf.
  - If fresh: q_new pulses 1 next cycle, stale <= 0, fresh <= 0. Otherwise stale <= 1 and there is no pulse.
- Frame completion and publish in the same cycle:
  - q receives the previous rx_buf, and q_new follows the previous fresh.
  - The new frame sets fresh <= 1; set has priority over clear.
- Priority within a cycle: reset > sample edge > shift edge > timeout. Sample and shift edges cannot coincide.
- Reset mid-frame: the partial frame is discarded and the next sample edge counts as bit 0. The PIC must restart the frame.
- Max sck frequency is clk/(2*(SYNC_STAGES+2)); behaviour above this is undefined.

Decomposition:
- Package spi_pkg:
  - localparam function frame_w(WORD_W, N_WORDS).
  - typedef enum for edge selection (SAMPLE_FALL, SAMPLE_RISE).
  - Constant ERR_W = 8.
- Sub-module sync_edge (params STAGES; ports clk, reset, d, q, rise, fall): instantiated for sck and update. sdo uses the same module with the edge outputs unused.
- Rest: single always_ff plus the sdi register; roughly 150–220 lines total.

Test Plan:
- Common settings: clk 40 MHz, sck 1 MHz, SYNC_STAGES=2.
- Basic 32-bit frame: WORD_W=32, N_WORDS=1, SAMPLE_RISE=0. PIC sends 0xA5C3_0F81 while tx_data=0x1234_5678; pulse update.
  - q==0xA5C3_0F81 and q_new pulses once.
  - Bits captured on the PIC side equal 0x1234_5678, MSB first.
- Two-word frame, opposite edge: N_WORDS=2, SAMPLE_RISE=1. Send 0xDEADBEEF_00000001.
  - rx_buf updates only after bit 64.
  - q after update == 0xDEADBEEF_00000001.
- Timeout resync: send 13 bits, stop sck for 1100 clk, then send a full frame 0xCAFEF00D.
  - err_cnt==1 and q==0xCAFEF00D.
  - The partial bits never appear in q.
- Publish without a new frame: two update edges with no SPI traffic between them.
  - Second edge gives stale==1, no q_new, q unchanged.
  - A following frame plus update gives stale==0.
- Collision: the last sample edge and the update rising edge land in the same clk.
  - q = previous frame.
  - fresh stays set, so the next update publishes the new frame with q_new.
- Reset mid-frame: assert reset for 1 clk after 10 bits.
  - All outputs return to their reset values (err_cnt==0).
  - The next 32-bit frame is received correctly.
